// File: rtl/cache_refill.sv
// rtl/cache_refill.sv - L1 miss line-refill engine: burst read, bank writes, critical word, tag write
module cache_refill #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 8,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_req_i,
  input  logic [ADDR_WIDTH-1:0]   miss_addr_i,
  output logic                    miss_ready_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  input  logic                    mem_ack_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rlast_i,
  output logic [INDEX_WIDTH-1:0]  data_index_o,
  output logic [OFFSET_WIDTH-1:0] data_offset_o,
  output logic [3:0]              data_wr_en_o,
  output logic [4*DATA_WIDTH-1:0] data_wr_data_o,
  output logic                    tag_wr_o,
  output logic [INDEX_WIDTH-1:0]  tag_index_o,
  output logic [TAG_WIDTH-1:0]    tag_o,
  output logic                    crit_valid_o,
  output logic [DATA_WIDTH-1:0]   crit_data_o,
  output logic                    refill_done_o,
  output logic                    refill_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RECV, TAG} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [1:0]              cnt_q;
  logic                    crit_valid_q;
  logic [DATA_WIDTH-1:0]   crit_data_q;
  logic                    err_q;
  logic                    beat;

  assign beat = (state_q == RECV) && mem_rvalid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      crit_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_req_i) begin
            addr_q  <= miss_addr_i;
            cnt_q   <= '0;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_ack_i) state_q <= RECV;
        end
        RECV: begin
          if (mem_rvalid_i) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == addr_q[3:2]) begin
              crit_data_q  <= mem_rdata_i;
              crit_valid_q <= 1'b1;
            end
            // A misplaced rlast is only flagged; the line is still filled from exactly 4 beats.
            if (mem_rlast_i != (cnt_q == 2'd3)) err_q <= 1'b1;
            if (cnt_q == 2'd3) state_q <= TAG;
          end
        end
        TAG: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_ready_o   = (state_q == IDLE);
  assign mem_req_o      = (state_q == REQ);
  assign mem_addr_o     = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};

  // Bank write port is combinational so each beat lands in the array the cycle it arrives.
  assign data_index_o   = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign data_offset_o  = {cnt_q, 2'b00};
  assign data_wr_en_o   = beat ? 4'hF : 4'h0;
  assign data_wr_data_o = beat ? {4{mem_rdata_i}} : '0;

  // Tag goes in only once every bank holds the new line.
  assign tag_wr_o       = (state_q == TAG);
  assign refill_done_o  = (state_q == TAG);
  assign tag_index_o    = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag_o          = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

  assign crit_valid_o   = crit_valid_q;
  assign crit_data_o    = crit_data_q;
  assign refill_err_o   = err_q;

endmodule

// File: tb/tb_cache_refill.sv
// tb/tb_cache_refill.sv - directed scoreboard bench for cache_refill
module tb_cache_refill;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         miss_req_i;
  logic [31:0]  miss_addr_i;
  logic         miss_ready_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_ack_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         mem_rlast_i;
  logic [7:0]   data_index_o;
  logic [3:0]   data_offset_o;
  logic [3:0]   data_wr_en_o;
  logic [127:0] data_wr_data_o;
  logic         tag_wr_o;
  logic [7:0]   tag_index_o;
  logic [19:0]  tag_o;
  logic         crit_valid_o;
  logic [31:0]  crit_data_o;
  logic         refill_done_o;
  logic         refill_err_o;

  int checks = 0;
  int errors = 0;

  logic [159:0] exp_wr[$];
  logic [159:0] exp_tag[$];
  logic [31:0]  exp_crit[$];
  int           exp_err = 0;

  cache_refill dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i),
    .data_index_o(data_index_o), .data_offset_o(data_offset_o),
    .data_wr_en_o(data_wr_en_o), .data_wr_data_o(data_wr_data_o),
    .tag_wr_o(tag_wr_o), .tag_index_o(tag_index_o), .tag_o(tag_o),
    .crit_valid_o(crit_valid_o), .crit_data_o(crit_data_o),
    .refill_done_o(refill_done_o), .refill_err_o(refill_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every write, tag write, critical word and error pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_wr_en_o !== 4'h0) begin
        chk("wr_en", 160'(data_wr_en_o), 160'(4'hF));
        chk("wr_expected", 160'(exp_wr.size() != 0), 160'(1'b1));
        if (exp_wr.size() != 0)
          chk("wr_port", 160'({data_index_o, data_offset_o, data_wr_data_o}), exp_wr.pop_front());
      end
      if (tag_wr_o !== 1'b0) begin
        chk("tag_expected", 160'(exp_tag.size() != 0), 160'(1'b1));
        if (exp_tag.size() != 0)
          chk("tag_port", 160'({refill_done_o, tag_index_o, tag_o}), exp_tag.pop_front());
      end
      if (refill_done_o !== tag_wr_o)
        chk("done_with_tag", 160'(refill_done_o), 160'(tag_wr_o));
      if (crit_valid_o !== 1'b0) begin
        chk("crit_expected", 160'(exp_crit.size() != 0), 160'(1'b1));
        if (exp_crit.size() != 0)
          chk("crit_data", 160'(crit_data_o), 160'(exp_crit.pop_front()));
      end
      if (refill_err_o !== 1'b0) begin
        chk("err_expected", 160'(exp_err > 0), 160'(1'b1));
        if (exp_err > 0) exp_err--;
      end
    end
  end

  // One refill: optional request phase, ack wait, beats per rvalid pattern (LSB first).
  // rlast is driven on beat rl_beat and on beat 3; abort_after>=0 returns after that many beats.
  task automatic refill(input logic [31:0] a, input bit already_req, input int ack_wait,
                        input logic [7:0] vpat, input int vlen, input int rl_beat,
                        input logic [31:0] base, input bit hold, input logic [31:0] a2,
                        input int abort_after);
    int beat = 0;
    logic crit_now, err_now;
    if (!already_req) begin
      miss_req_i  = 1'b1;
      miss_addr_i = a;
      chk("ready_before_miss", 160'(miss_ready_o), 160'(1'b1));
      step();
      if (hold) miss_addr_i = a2;
      else miss_req_i = 1'b0;
    end
    chk("mem_req", 160'(mem_req_o), 160'(1'b1));
    chk("mem_addr", 160'(mem_addr_o), 160'({a[31:4], 4'h0}));
    chk("ready_busy", 160'(miss_ready_o), 160'(1'b0));
    for (int w = 0; w < ack_wait; w++) begin
      step();
      chk("mem_req_held", 160'({mem_req_o, mem_addr_o}), 160'({1'b1, a[31:4], 4'h0}));
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i = 1'b0;
    chk("req_dropped", 160'(mem_req_o), 160'(1'b0));
    for (int i = 0; i < vlen && beat < 4; i++) begin
      crit_now = 1'b0;
      err_now  = 1'b0;
      mem_rvalid_i = vpat[i];
      if (vpat[i]) begin
        mem_rdata_i = base + 32'(beat);
        mem_rlast_i = (beat == rl_beat) || (beat == 3);
        exp_wr.push_back(160'({a[11:4], 2'(beat), 2'b00, {4{mem_rdata_i}}}));
        if (beat == int'(a[3:2])) begin
          crit_now = 1'b1;
          exp_crit.push_back(mem_rdata_i);
        end
        if (mem_rlast_i != (beat == 3)) begin
          err_now = 1'b1;
          exp_err++;
        end
        if (beat == 3) exp_tag.push_back(160'({1'b1, a[11:4], a[31:12]}));
        beat++;
      end else begin
        mem_rdata_i = $urandom();
        mem_rlast_i = 1'b0;
      end
      step();
      chk("crit_pulse", 160'(crit_valid_o), 160'(crit_now));
      chk("err_pulse", 160'(refill_err_o), 160'(err_now));
      if (beat == abort_after) begin
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        return;
      end
    end
    mem_rvalid_i = 1'b0;
    mem_rlast_i  = 1'b0;
    chk("tag_after_last", 160'({tag_wr_o, refill_done_o, miss_ready_o}), 160'(3'b110));
    chk("tag_value", 160'({tag_index_o, tag_o}), 160'({a[11:4], a[31:12]}));
    step();
    chk("ready_after_tag", 160'({miss_ready_o, tag_wr_o, refill_done_o}), 160'(3'b100));
  endtask

  initial begin
    rst_n = 1'b0;
    miss_req_i = 1'b0; miss_addr_i = '0; mem_ack_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_rlast_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 160'(miss_ready_o), 160'(1'b1));
    chk("rst_strobes", 160'({mem_req_o, data_wr_en_o, tag_wr_o, refill_done_o, crit_valid_o, refill_err_o}), 160'(0));
    chk("rst_values", 160'({mem_addr_o, data_index_o, data_offset_o, tag_index_o, tag_o, crit_data_o}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    refill(32'h0000_1238, 1'b0, 2, 8'b0000_1111, 4, 3, 32'h0000_00A0, 1'b0, '0, -1);
    chk("basic_crit_held", 160'(crit_data_o), 160'(32'hA2));

    refill(32'h0000_1238, 1'b0, 0, 8'b0101_1001, 7, 3, 32'h0000_00B0, 1'b0, '0, -1);

    refill(32'h8000_0FF0, 1'b0, 1, 8'b0000_1111, 4, 3, 32'h0000_00C0, 1'b0, '0, -1);
    chk("crit0_data", 160'(crit_data_o), 160'(32'hC0));

    refill(32'h0000_4444, 1'b0, 0, 8'b0000_1111, 4, 1, 32'h0000_00D0, 1'b0, '0, -1);

    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hDEAD_BEEF;
    chk("rvalid_idle_no_write", 160'(data_wr_en_o), 160'(4'h0));
    step();
    chk("rvalid_idle_state", 160'({miss_ready_o, data_wr_en_o}), 160'({1'b1, 4'h0}));
    mem_rvalid_i = 1'b0;

    refill(32'h0000_5678, 1'b0, 0, 8'b0000_1111, 4, 3, 32'h0000_00E0, 1'b0, '0, 2);
    rst_n = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    chk("abort_ready", 160'(miss_ready_o), 160'(1'b1));
    chk("abort_strobes", 160'({mem_req_o, data_wr_en_o, tag_wr_o, refill_done_o, crit_valid_o, refill_err_o}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid_i = 1'b0;
    step();
    chk("abort_ready_release", 160'({miss_ready_o, tag_wr_o}), 160'(2'b10));

    refill(32'h0000_1000, 1'b0, 1, 8'b0000_1111, 4, 3, 32'h0000_0010, 1'b1, 32'h0000_2ABC, -1);
    step();
    miss_req_i = 1'b0;
    refill(32'h0000_2ABC, 1'b1, 0, 8'b0000_1111, 4, 3, 32'h0000_0020, 1'b0, '0, -1);
    step();

    chk("wr_queue_empty", 160'(exp_wr.size()), 160'(0));
    chk("tag_queue_empty", 160'(exp_tag.size()), 160'(0));
    chk("crit_queue_empty", 160'(exp_crit.size()), 160'(0));
    chk("err_all_seen", 160'(exp_err), 160'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
